// File: rtl/move_tick_scheduler.sv
// move_tick_scheduler: paces snake moves with one-cycle MOVE_TICK pulses.
// Period shrinks with speed level; ticks can be aligned to VS falling edge.
module move_tick_scheduler #(
  parameter int TICKS_BASE = 25000000,
  parameter int TICKS_MIN  = 5000000,
  parameter int SPEED_STEP = 1000000,
  parameter int MAX_LEVEL  = 15,
  parameter int CNT_W      = 25,
  parameter int SYNC_EN    = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MASTER_STATE,
  input  logic       REACHED,
  input  logic       VS,
  input  logic [1:0] DIRECTION_REQ,
  output logic       MOVE_TICK,
  output logic [1:0] DIRECTION_OUT,
  output logic [3:0] SPEED_LEVEL
);

  localparam int PW = CNT_W + 5;

  localparam logic [1:0] MS_IDLE   = 2'b00;
  localparam logic [1:0] MS_PLAY   = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_FLIP  = 2'b10;

  localparam logic [PW-1:0] BASE_W = PW'(TICKS_BASE);
  localparam logic [PW-1:0] MIN_W  = PW'(TICKS_MIN);
  localparam logic [PW-1:0] STEP_W = PW'(SPEED_STEP);
  localparam logic [3:0]    LVL_MAX = 4'(MAX_LEVEL);

  localparam logic [CNT_W-1:0] PER0 =
    (TICKS_BASE < TICKS_MIN) ? CNT_W'(TICKS_MIN)
                             : CNT_W'(TICKS_BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] reload;
  logic             tick_q, tick_d;
  logic [1:0]       dir_q, dir_d;
  logic [3:0]       lvl_q, lvl_d;

  logic vs_s1_q, vs_s2_q, vs_h_q;
  logic vs_fall;
  logic play;
  logic fire;

  logic [PW-1:0] dec;
  logic          per_floor;

  assign play    = (MASTER_STATE == MS_PLAY);
  assign vs_fall = vs_h_q & ~vs_s2_q;
  assign reload  = per_q - CNT_W'(1);

  // Bring VS into the clock domain and keep one cycle of history.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      vs_h_q  <= 1'b1;
    end else begin
      vs_s1_q <= VS;
      vs_s2_q <= vs_s1_q;
      vs_h_q  <= vs_s2_q;
    end
  end

  // Period from level, clamped to the floor without wrapping.
  always_comb begin
    dec       = PW'(lvl_q) * STEP_W;
    per_floor = (dec >= BASE_W) || ((BASE_W - dec) < MIN_W);
    per_d     = per_floor ? CNT_W'(MIN_W) : CNT_W'(BASE_W - dec);
  end

  // Next-state, counter, tick, direction and level logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    lvl_d   = lvl_q;
    fire    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (play) begin
          state_d = S_COUNT;
          cnt_d   = reload;
        end
      end
      S_COUNT: begin
        if (!play) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (SYNC_EN == 0) begin
          fire  = 1'b1;
          cnt_d = reload;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!play) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (vs_fall) begin
          fire    = 1'b1;
          cnt_d   = reload;
          state_d = S_COUNT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    tick_d = fire;
    if (fire && (DIRECTION_REQ != (dir_q ^ DIR_FLIP)))
      dir_d = DIRECTION_REQ;
    if (play && REACHED && (lvl_q < LVL_MAX))
      lvl_d = lvl_q + 4'd1;
    if (MASTER_STATE == MS_IDLE) begin
      lvl_d = '0;
      dir_d = DIR_RIGHT;
    end
  end

  // Scheduler state, period and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= PER0;
      tick_q  <= 1'b0;
      dir_q   <= DIR_RIGHT;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      dir_q   <= dir_d;
      lvl_q   <= lvl_d;
    end
  end

  assign MOVE_TICK     = tick_q;
  assign DIRECTION_OUT = dir_q;
  assign SPEED_LEVEL   = lvl_q;

endmodule

// File: tb/tb_move_tick_scheduler.sv
// tb_move_tick_scheduler: directed and random checks of both sync modes
// against a timestamp-based reference model.
module tb_move_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ms;
  logic       reached;
  logic       vs;
  logic [1:0] req;

  logic       tick0, tick1;
  logic [1:0] dir0, dir1;
  logic [3:0] lvl0, lvl1;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  int m_level[2];
  int m_dir[2];
  int m_tick[2];
  int m_active[2];
  int m_deadline[2];
  int m_p[2];
  bit vh[3];

  always #5 clk = ~clk;

  move_tick_scheduler #(
    .TICKS_BASE(10), .TICKS_MIN(4), .SPEED_STEP(2),
    .MAX_LEVEL(15), .CNT_W(5), .SYNC_EN(0)
  ) u0 (
    .CLK(clk), .RESET(rst_n), .MASTER_STATE(ms),
    .REACHED(reached), .VS(vs), .DIRECTION_REQ(req),
    .MOVE_TICK(tick0), .DIRECTION_OUT(dir0), .SPEED_LEVEL(lvl0)
  );

  move_tick_scheduler #(
    .TICKS_BASE(10), .TICKS_MIN(4), .SPEED_STEP(2),
    .MAX_LEVEL(15), .CNT_W(5), .SYNC_EN(1)
  ) u1 (
    .CLK(clk), .RESET(rst_n), .MASTER_STATE(ms),
    .REACHED(reached), .VS(vs), .DIRECTION_REQ(req),
    .MOVE_TICK(tick1), .DIRECTION_OUT(dir1), .SPEED_LEVEL(lvl1)
  );

  function automatic int period(int lv);
    int p;
    p = 10 - lv * 2;
    return (p < 4) ? 4 : p;
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d at edge %0d",
             tag, obs, exp, n);
    end
  endtask

  // Reference: a tick is due P edges after start/reload (free-running),
  // or at the first VS fall strictly after that point (synced).
  task automatic model_edge();
    bit vf;
    int np;
    vf = vh[2] && !vh[1];
    for (int i = 0; i < 2; i++) begin
      np = period(m_level[i]);
      m_tick[i] = 0;
      if (!rst_n) begin
        m_level[i] = 0;
        m_dir[i] = 1;
        m_active[i] = 0;
        m_p[i] = period(0);
      end else begin
        if (ms != 2'b01) begin
          m_active[i] = 0;
          if (ms == 2'b00) begin
            m_level[i] = 0;
            m_dir[i] = 1;
          end
        end else begin
          if (m_active[i] == 0) begin
            m_active[i] = 1;
            m_deadline[i] = n + m_p[i];
          end else if ((i == 0 && n == m_deadline[i]) ||
                       (i == 1 && n > m_deadline[i] && vf)) begin
            m_tick[i] = 1;
            if (int'(req) != (m_dir[i] ^ 2))
              m_dir[i] = int'(req);
            m_deadline[i] = n + m_p[i];
          end
          if (reached && m_level[i] < 15)
            m_level[i]++;
        end
        m_p[i] = np;
      end
    end
    if (!rst_n) begin
      vh[0] = 1; vh[1] = 1; vh[2] = 1;
    end else begin
      vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vs;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    n++;
    check("tick0", 16'(tick0), 16'(m_tick[0]));
    check("dir0",  16'(dir0),  16'(m_dir[0]));
    check("lvl0",  16'(lvl0),  16'(m_level[0]));
    check("tick1", 16'(tick1), 16'(m_tick[1]));
    check("dir1",  16'(dir1),  16'(m_dir[1]));
    check("lvl1",  16'(lvl1),  16'(m_level[1]));
  endtask

  task automatic until_tick(input int bound, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (tick0 !== 1'b1 && k < bound);
  endtask

  task automatic pulse(input int cnt);
    repeat (cnt) begin
      reached = 1'b1; step();
      reached = 1'b0; step();
    end
    step(); step();
  endtask

  task automatic gap_check(string tag, int exp);
    int k;
    until_tick(40, k);
    until_tick(40, k);
    check(tag, 16'(k), 16'(exp));
  endtask

  initial begin
    int k;
    int seen;
    int vs_left;
    int r;
    rst_n = 1'b0; ms = 2'b00; reached = 1'b0;
    vs = 1'b1; req = 2'b01;
    vh[0] = 1; vh[1] = 1; vh[2] = 1;
    step(); step();
    check("rst_tick", 16'(tick0), 16'h0);
    check("rst_dir",  16'(dir0),  16'h1);
    check("rst_lvl",  16'(lvl0),  16'h0);
    rst_n = 1'b1;
    step();

    ms = 2'b01;
    until_tick(40, k);
    check("first_tick", 16'(k), 16'd11);
    check("first_dir", 16'(dir0), 16'h1);
    until_tick(40, k);
    check("period10_a", 16'(k), 16'd10);
    until_tick(40, k);
    check("period10_b", 16'(k), 16'd10);

    pulse(1);
    check("lvl1", 16'(lvl0), 16'd1);
    gap_check("gap_lvl1", 8);
    pulse(1);
    check("lvl2", 16'(lvl0), 16'd2);
    gap_check("gap_lvl2", 6);
    pulse(1);
    check("lvl3", 16'(lvl0), 16'd3);
    gap_check("gap_lvl3", 4);
    pulse(2);
    check("lvl5", 16'(lvl0), 16'd5);
    gap_check("gap_lvl5", 4);
    pulse(15);
    check("lvl_sat", 16'(lvl0), 16'd15);

    ms = 2'b00; step(); step();
    ms = 2'b01; req = 2'b11;
    until_tick(40, k);
    check("rev_first", 16'(k), 16'd11);
    check("rev_ignored", 16'(dir0), 16'h1);
    req = 2'b10;
    step();
    check("dir_hold", 16'(dir0), 16'h1);
    until_tick(40, k);
    check("dir_taken", 16'(dir0), 16'h2);

    until_tick(40, k);
    repeat (8) step();
    ms = 2'b00; step(); step();
    check("drop_notick", 16'(tick0), 16'h0);
    check("drop_lvl", 16'(lvl0), 16'h0);
    step();
    ms = 2'b01;
    until_tick(40, k);
    check("restart", 16'(k), 16'd11);

    ms = 2'b00; step(); step();
    ms = 2'b01; vs = 1'b1; seen = 0;
    repeat (30) begin
      step();
      if (tick1 === 1'b1) seen++;
    end
    check("nosync", 16'(seen), 16'd0);
    vs = 1'b0;
    step(); step(); step();
    check("sync_tick", 16'(tick1), 16'h1);
    vs = 1'b1;
    step(); step();

    pulse(3);
    check("pre_rst_lvl", 16'(lvl0), 16'd3);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    check("mrst_tick", 16'(tick0), 16'h0);
    check("mrst_dir", 16'(dir0), 16'h1);
    check("mrst_lvl", 16'(lvl0), 16'h0);
    rst_n = 1'b1;
    until_tick(40, k);
    check("post_rst", 16'(k), 16'd11);

    vs_left = 4;
    for (int c = 0; c < 2500; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 59) == 0) begin
        r = $urandom_range(0, 9);
        ms = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 :
             (r == 8) ? 2'b10 : 2'b11;
      end
      reached = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0)
        req = 2'($urandom_range(0, 3));
      if (vs_left == 0) begin
        vs = ~vs;
        vs_left = $urandom_range(1, 12);
      end else begin
        vs_left--;
      end
      step();
    end
    reached = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/move_tick_scheduler.md
Name: move_tick_scheduler

Overview:
Paces snake movement for the game core. It issues one-cycle MOVE_TICK pulses to the snake controller while the master state is PLAY. The tick period shrinks as targets are eaten. Each tick can optionally be aligned to the VGA vertical-sync falling edge, and the next direction is latched with 180-degree reversals rejected.

Parameters:
TICKS_BASE, 25000000, tick period in CLK cycles at speed level 0 (4 moves/s at 100 MHz).
TICKS_MIN, 5000000, floor on the tick period.
SPEED_STEP, 1000000, period reduction per speed level.
MAX_LEVEL, 15, saturation value of SPEED_LEVEL.
CNT_W, 25, period counter width; must hold TICKS_BASE-1.
SYNC_EN, 1, 1 = tick waits for VS falling edge, 0 = free-running.

Ports:
CLK  in  1  system clock (100 MHz)
RESET  in  1  synchronous, active-low reset
MASTER_STATE  in  2  game state: 00 IDLE, 01 PLAY, 10 WIN, 11 reserved
REACHED  in  1  one-cycle pulse when the snake eats a target
VS  in  1  VGA vertical sync, active low, asynchronous to scheduler logic
DIRECTION_REQ  in  2  requested direction: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT
MOVE_TICK  out  1  one-cycle pulse: advance snake one cell
DIRECTION_OUT  out  2  direction valid with and held after MOVE_TICK
SPEED_LEVEL  out  4  current speed level, 0..MAX_LEVEL

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - state=IDLE, counter=0
  - MOVE_TICK=0, DIRECTION_OUT=01 (RIGHT), SPEED_LEVEL=0
  - VS synchroniser and edge-history flops = 1
- VS handling: double-flop synchronise, then keep one history flop. vs_fall = history==1 && synchronised==0, one cycle wide.
- Period calculation:
  - P = max(TICKS_BASE - SPEED_LEVEL*SPEED_STEP, TICKS_MIN)
  - Compute in CNT_W+5 bits, signed or guarded, so the subtraction never wraps.
  - P is registered, so it updates one cycle after a SPEED_LEVEL change.
- State machine (state register updates every CLK edge):
  - IDLE: MOVE_TICK=0. If MASTER_STATE==PLAY, go to COUNT and load counter=P-1.
  - COUNT: if MASTER_STATE!=PLAY, go to IDLE. Otherwise:
    - counter>0: decrement.
    - counter==0 and SYNC_EN=0: assert MOVE_TICK next cycle, reload counter=P-1, stay in COUNT.
    - counter==0 and SYNC_EN=1: go to WAIT_SYNC.
  - WAIT_SYNC: if MASTER_STATE!=PLAY, go to IDLE. Otherwise, on vs_fall assert MOVE_TICK next cycle, reload counter=P-1 and go to COUNT.
  - A vs_fall already in progress at WAIT_SYNC entry is not counted retroactively.
- Tick latency:
  - SYNC_EN=0: first MOVE_TICK is exactly P cycles after the edge that sampled PLAY; after that, ticks are exactly P cycles apart.
  - SYNC_EN=1: tick spacing is >= P, and each tick lands 1 cycle after the vs_fall cycle.
- MOVE_TICK is registered, high for exactly one cycle, and never asserted outside PLAY.
- Direction handling:
  - On each MOVE_TICK cycle, DIRECTION_OUT takes DIRECTION_REQ sampled on the preceding cycle.
  - A reversal (DIRECTION_REQ == DIRECTION_OUT XOR 2'b10) is ignored and DIRECTION_OUT holds.
  - Between ticks DIRECTION_OUT is stable.
- Speed level:
  - REACHED in PLAY increments SPEED_LEVEL, saturating at MAX_LEVEL. REACHED outside PLAY is ignored.
  - MASTER_STATE==IDLE clears SPEED_LEVEL to 0 and DIRECTION_OUT to 01.
  - WIN holds both values.
- Simultaneous events:
  - REACHED on the reload cycle: the counter reloads with the old P. The new level applies at the following reload.
  - MASTER_STATE leaving PLAY on the same cycle a tick would issue: no tick. IDLE wins.
- Mid-operation:
  - Reset or a leave-PLAY at any point clears the counter.
  - Re-entry to PLAY always restarts a full period; a partial count is never resumed.

Test Plan:
1. Params TICKS_BASE=10, TICKS_MIN=4, SPEED_STEP=2, SYNC_EN=0; reset, then MASTER_STATE=01 -> first MOVE_TICK 10 cycles after PLAY sampled, then every 10 cycles; DIRECTION_OUT=01.
2. Same params; pulse REACHED 1, 2, 3 and 5 times -> SPEED_LEVEL 1, 2, 3, 5 and tick spacing 8, 6, 4, 4 (floor); with MAX_LEVEL=15, 20 pulses give SPEED_LEVEL=15.
3. DIRECTION_OUT=01; DIRECTION_REQ=11 (reversal) -> unchanged after tick; DIRECTION_REQ=10 -> DIRECTION_OUT=10 on the next tick, not before.
4. SYNC_EN=1, VS falls 3 cycles after the counter hits 0 -> MOVE_TICK 1 cycle after vs_fall (synchroniser latency included); no tick without a VS edge.
5. MASTER_STATE drops to 00 one cycle before an expected tick -> no MOVE_TICK, SPEED_LEVEL=0; back to 01 -> full 10-cycle period restarts.
6. RESET=0 for one edge mid-count at level 3 -> all outputs take reset values next cycle, and no tick until a new PLAY period elapses.
